foc_cmd_sched: RTL and testbench

- Sits between the FOC command receiver and the FOC control loop.
- Holds the most recent validated command (mode, target, damping, id) as pending.
- Commits pending commands to the loop only on loop_tick boundaries. A change between two nonzero modes passes through an idle drain interval first.
- A tick-based watchdog forces idle when commands stop arriving.

---
 rtl/foc_cmd_sched_pkg.sv | 21 ++
 rtl/foc_cmd_wdog.sv | 32 +++
 rtl/foc_cmd_sched.sv | 135 +++++++++++++
 tb/tb_foc_cmd_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/foc_cmd_sched_pkg.sv
// Shared definitions for the FOC command scheduler and the status/telemetry blocks
// that decode its state output.
package foc_cmd_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_TIMEOUT = 2'd3
    } sched_state_t;

    localparam logic [7:0] MODE_IDLE = 8'd0;

    typedef struct packed {
        logic [7:0]  mode;
        logic [31:0] target;
        logic [31:0] damping;
        logic [31:0] id;
    } foc_cmd_t;

endpackage

// File: rtl/foc_cmd_wdog.sv
// Tick-driven saturating watchdog: counts enabled loop ticks since the last clear and
// flags the tick on which the count would reach TIMEOUT_TICKS (0 disables it).
module foc_cmd_wdog
    import foc_cmd_sched_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_TICKS = 16'd1000
) (
    input  logic c,
    input  logic rst,
    input  logic tick,
    input  logic en,
    input  logic clr,
    output logic expire
);

    logic [15:0] count;

    // A clear in the same cycle as a tick wins, so that tick can never expire.
    assign expire = tick && en && !clr && (TIMEOUT_TICKS != 16'd0)
                    && (count >= TIMEOUT_TICKS - 16'd1);

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            count <= 16'd0;
        end else if (clr) begin
            count <= 16'd0;
        end else if (tick && en && count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/foc_cmd_sched.sv
// Holds the latest legal command as pending and commits it to the FOC loop on
// loop_tick boundaries, inserting an idle drain between different nonzero modes.
module foc_cmd_sched
    import foc_cmd_sched_pkg::*;
#(
    parameter logic [7:0]  MAX_MODE      = 8'd3,
    parameter int          DRAIN_TICKS   = 4,
    parameter logic [15:0] TIMEOUT_TICKS = 16'd1000
) (
    input  logic        c,
    input  logic        rst,
    input  logic        cmd_rx,
    input  logic [7:0]  cmd_mode,
    input  logic [31:0] cmd_id,
    input  logic [31:0] cmd_target,
    input  logic [31:0] cmd_damping,
    input  logic        loop_tick,
    output logic [7:0]  out_mode,
    output logic [31:0] out_target,
    output logic [31:0] out_damping,
    output logic [31:0] out_id,
    output logic        apply,
    output logic        reject,
    output logic        timeout,
    output logic [1:0]  state
);

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TICKS - 1);

    sched_state_t st;
    foc_cmd_t     pend;
    logic         pending_valid;
    logic [7:0]   drain_cnt;
    logic         legal;
    logic         accept;
    logic         expire;
    logic         wd_en;
    logic         do_commit;
    logic         do_drain;

    // cmd_rx and loop_tick are single-cycle strobes with no back-pressure: cmd_* are
    // sampled only when cmd_rx is high, and a tick only ever sees pending as it stood
    // before that cycle's command.
    assign legal  = cmd_mode <= MAX_MODE;
    assign accept = cmd_rx && legal;
    assign wd_en  = (st == ST_RUN) || (st == ST_DRAIN);
    assign state  = st;

    foc_cmd_wdog #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_wdog (
        .c      (c),
        .rst    (rst),
        .tick   (loop_tick),
        .en     (wd_en),
        .clr    (accept),
        .expire (expire)
    );

    always_comb begin
        do_commit = 1'b0;
        do_drain  = 1'b0;
        if (loop_tick && !expire) begin
            case (st)
                ST_IDLE:  do_commit = pending_valid;
                ST_RUN: begin
                    if (pending_valid) begin
                        if (pend.mode == out_mode || pend.mode == MODE_IDLE) do_commit = 1'b1;
                        else                                                 do_drain  = 1'b1;
                    end
                end
                ST_DRAIN: do_commit = (drain_cnt == DRAIN_LAST);
                default:  ;
            endcase
        end
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            st            <= ST_IDLE;
            pend          <= '0;
            pending_valid <= 1'b0;
            drain_cnt     <= 8'd0;
            out_mode      <= MODE_IDLE;
            out_target    <= 32'd0;
            out_damping   <= 32'd0;
            out_id        <= 32'd0;
            apply         <= 1'b0;
            reject        <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            apply  <= 1'b0;
            reject <= cmd_rx && !legal;

            if (expire) begin
                out_mode      <= MODE_IDLE;
                out_target    <= 32'd0;
                out_damping   <= 32'd0;
                apply         <= 1'b1;
                timeout       <= 1'b1;
                pending_valid <= 1'b0;
                st            <= ST_TIMEOUT;
            end else if (do_commit) begin
                out_mode      <= pend.mode;
                out_target    <= pend.target;
                out_damping   <= pend.damping;
                out_id        <= pend.id;
                apply         <= 1'b1;
                pending_valid <= 1'b0;
                st            <= (pend.mode == MODE_IDLE) ? ST_IDLE : ST_RUN;
            end else if (do_drain) begin
                // Pending stays valid; it is committed (possibly overwritten) at drain end.
                out_mode    <= MODE_IDLE;
                out_target  <= 32'd0;
                out_damping <= 32'd0;
                apply       <= 1'b1;
                drain_cnt   <= 8'd0;
                st          <= ST_DRAIN;
            end else if (loop_tick && st == ST_DRAIN && drain_cnt != 8'hFF) begin
                drain_cnt <= drain_cnt + 8'd1;
            end

            if (accept) begin
                pend          <= '{mode: cmd_mode, target: cmd_target,
                                   damping: cmd_damping, id: cmd_id};
                pending_valid <= 1'b1;
                if (st == ST_TIMEOUT) begin
                    timeout <= 1'b0;
                    st      <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_foc_cmd_sched.sv
// Directed and randomized bench for foc_cmd_sched, checked cycle by cycle against a
// rule-level model of the command scheduler.
module tb_foc_cmd_sched;

    localparam int TB_MAX   = 3;
    localparam int TB_DRAIN = 4;
    localparam int TB_TO    = 8;

    logic        c = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_rx = 1'b0;
    logic [7:0]  cmd_mode = 8'd0;
    logic [31:0] cmd_id = 32'd0;
    logic [31:0] cmd_target = 32'd0;
    logic [31:0] cmd_damping = 32'd0;
    logic        loop_tick = 1'b0;
    logic [7:0]  out_mode;
    logic [31:0] out_target;
    logic [31:0] out_damping;
    logic [31:0] out_id;
    logic        apply;
    logic        reject;
    logic        timeout;
    logic [1:0]  state;

    int checks = 0;
    int failures = 0;

    foc_cmd_sched #(
        .MAX_MODE      (8'(TB_MAX)),
        .DRAIN_TICKS   (TB_DRAIN),
        .TIMEOUT_TICKS (16'(TB_TO))
    ) dut (
        .c           (c),
        .rst         (rst),
        .cmd_rx      (cmd_rx),
        .cmd_mode    (cmd_mode),
        .cmd_id      (cmd_id),
        .cmd_target  (cmd_target),
        .cmd_damping (cmd_damping),
        .loop_tick   (loop_tick),
        .out_mode    (out_mode),
        .out_target  (out_target),
        .out_damping (out_damping),
        .out_id      (out_id),
        .apply       (apply),
        .reject      (reject),
        .timeout     (timeout),
        .state       (state)
    );

    always #5 c = ~c;

    // Model: phase 0 idle, 1 running, 2 draining, 3 timed out.
    int          m_phase;
    logic [7:0]  m_mode;
    logic [31:0] m_tgt, m_dmp, m_id;
    bit          m_apply, m_reject, m_to;
    bit          q_valid;
    logic [7:0]  q_mode;
    logic [31:0] q_tgt, q_dmp, q_id;
    int          m_wd;
    int          m_drain_seen;

    task automatic model_reset();
        m_phase = 0; m_mode = 0; m_tgt = 0; m_dmp = 0; m_id = 0;
        m_apply = 0; m_reject = 0; m_to = 0;
        q_valid = 0; q_mode = 0; q_tgt = 0; q_dmp = 0; q_id = 0;
        m_wd = 0; m_drain_seen = 0;
    endtask

    task automatic take_pending();
        m_mode = q_mode; m_tgt = q_tgt; m_dmp = q_dmp; m_id = q_id;
        m_apply = 1; q_valid = 0;
        m_phase = (q_mode == 0) ? 0 : 1;
    endtask

    task automatic model_edge(input bit rx, input logic [7:0] md, input logic [31:0] id,
                              input logic [31:0] tg, input logic [31:0] dp, input bit tk);
        bit ok;
        bit active;
        ok = rx && (md <= TB_MAX);
        active = (m_phase == 1) || (m_phase == 2);
        m_apply = 0;
        m_reject = rx && (md > TB_MAX);
        if (tk) begin
            if (active && !ok) m_wd++;
            if (active && !ok && TB_TO != 0 && m_wd >= TB_TO) begin
                m_mode = 0; m_tgt = 0; m_dmp = 0;
                m_apply = 1; m_to = 1; q_valid = 0; m_phase = 3;
            end else if (m_phase == 2) begin
                m_drain_seen++;
                if (m_drain_seen == TB_DRAIN) take_pending();
            end else if (q_valid && (m_phase == 0 || q_mode == 0 || q_mode == m_mode)) begin
                take_pending();
            end else if (q_valid && m_phase == 1) begin
                m_mode = 0; m_tgt = 0; m_dmp = 0;
                m_apply = 1; m_phase = 2; m_drain_seen = 0;
            end
        end
        if (ok) begin
            q_valid = 1; q_mode = md; q_tgt = tg; q_dmp = dp; q_id = id;
            m_wd = 0;
            if (m_phase == 3) begin
                m_phase = 0; m_to = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out_mode"}, 32'(out_mode), 32'(m_mode));
        chk({tag, ".out_target"}, out_target, m_tgt);
        chk({tag, ".out_damping"}, out_damping, m_dmp);
        chk({tag, ".out_id"}, out_id, m_id);
        chk({tag, ".apply"}, 32'(apply), 32'(m_apply));
        chk({tag, ".reject"}, 32'(reject), 32'(m_reject));
        chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
        chk({tag, ".state"}, 32'(state), 32'(m_phase));
    endtask

    task automatic step(input bit rx, input logic [7:0] md, input logic [31:0] id,
                        input logic [31:0] tg, input logic [31:0] dp, input bit tk,
                        input string tag);
        cmd_rx = rx; cmd_mode = md; cmd_id = id;
        cmd_target = tg; cmd_damping = dp; loop_tick = tk;
        @(posedge c);
        model_edge(rx, md, id, tg, dp, tk);
        @(negedge c);
        cmd_rx = 1'b0;
        loop_tick = 1'b0;
        check_model(tag);
    endtask

    task automatic cmd(input logic [7:0] md, input logic [31:0] id, input string tag);
        step(1, md, id, 32'h1000 + id, 32'h200 + id, 0, tag);
    endtask

    task automatic tick(input string tag);
        step(0, 8'd0, 32'd0, 32'd0, 32'd0, 1, tag);
    endtask

    task automatic idle(input string tag);
        step(0, 8'd0, 32'd0, 32'd0, 32'd0, 0, tag);
    endtask

    initial begin
        model_reset();
        @(negedge c);
        check_model("reset");
        @(negedge c);
        rst = 1'b0;

        // First command from idle.
        step(1, 8'd1, 32'd7, 32'h100, 32'h20, 0, "first_cmd");
        tick("first_tick");
        chk("first.out_mode", 32'(out_mode), 32'd1);
        chk("first.out_target", out_target, 32'h100);
        chk("first.out_id", out_id, 32'd7);
        chk("first.state", 32'(state), 32'd1);
        idle("first_idle");

        // Mode 1 -> 2 passes through DRAIN_TICKS idle periods.
        cmd(8'd2, 32'd8, "drain_cmd");
        tick("drain_t1");
        chk("drain_t1.out_mode", 32'(out_mode), 32'd0);
        chk("drain_t1.apply", 32'(apply), 32'd1);
        chk("drain_t1.out_id", out_id, 32'd7);
        for (int i = 2; i <= 4; i++) begin
            idle("drain_gap");
            tick("drain_mid");
        end
        tick("drain_t5");
        chk("drain_t5.out_mode", 32'(out_mode), 32'd2);
        chk("drain_t5.out_id", out_id, 32'd8);
        chk("drain_t5.apply", 32'(apply), 32'd1);

        // Command overwriting pending during a drain.
        cmd(8'd3, 32'd10, "ovr_cmd");
        tick("ovr_t1");
        tick("ovr_t2");
        cmd(8'd1, 32'd9, "ovr_new");
        tick("ovr_t3");
        tick("ovr_t4");
        tick("ovr_t5");
        chk("ovr.out_mode", 32'(out_mode), 32'd1);
        chk("ovr.out_id", out_id, 32'd9);
        chk("ovr.state", 32'(state), 32'd1);

        // Illegal mode.
        cmd(8'd5, 32'd55, "rej_cmd");
        chk("rej.reject", 32'(reject), 32'd1);
        tick("rej_tick");
        chk("rej.apply", 32'(apply), 32'd0);
        chk("rej.out_id", out_id, 32'd9);

        // Watchdog expiry, then recovery by a new command.
        cmd(8'd1, 32'd11, "wd_cmd");
        tick("wd_commit");
        for (int i = 0; i < 10; i++) tick("wd_tick");
        chk("wd.timeout", 32'(timeout), 32'd1);
        chk("wd.state", 32'(state), 32'd3);
        chk("wd.out_mode", 32'(out_mode), 32'd0);
        chk("wd.out_id", out_id, 32'd11);
        cmd(8'd1, 32'd12, "wd_recover");
        chk("wd_recover.timeout", 32'(timeout), 32'd0);
        chk("wd_recover.apply", 32'(apply), 32'd0);
        tick("wd_recover_tick");
        chk("wd_recover.out_id", out_id, 32'd12);
        chk("wd_recover.out_mode", 32'(out_mode), 32'd1);

        // Command coincident with a tick is not visible to that tick.
        step(1, 8'd1, 32'd13, 32'h55, 32'h66, 1, "coinc");
        chk("coinc.apply", 32'(apply), 32'd0);
        tick("coinc_next");
        chk("coinc_next.apply", 32'(apply), 32'd1);
        chk("coinc_next.out_id", out_id, 32'd13);

        // Asynchronous reset in the middle of a drain.
        cmd(8'd2, 32'd14, "rst_cmd");
        tick("rst_drain");
        tick("rst_drain2");
        rst = 1'b1;
        #1;
        model_reset();
        check_model("async_rst");
        @(posedge c);
        @(negedge c);
        check_model("rst_hold");
        rst = 1'b0;
        tick("post_rst_tick");

        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) == 0, 8'($urandom_range(0, 5)), $urandom, $urandom,
                 $urandom, $urandom_range(0, 2) == 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
